// File: rtl/seg7_result_display.sv
// seg7_result_display
//   Captures the MLP accumulator result on each accepted valid strobe and
//   shows one 16-bit half of it as four hex digits on a multiplexed
//   common-anode seven-segment display.
//
// Parameters
//   CLOCK_FREQ   : clock frequency in Hz
//   DIGIT_HZ     : digit-advance rate; DIV = CLOCK_FREQ/DIGIT_HZ cycles per dwell (DIV >= 4)
//   BLANK_CYCLES : anode-off cycles at the start of each dwell (0 <= BLANK_CYCLES < DIV)
//
// Ports
//   clk             : system clock
//   rst_n           : asynchronous active-low reset
//   value_i         : signed accumulator value, displayed as raw hex
//   value_valid_i   : single-cycle capture strobe
//   page_sel_i      : 0 = show bits [15:0], 1 = show bits [31:16]
//   freeze_i        : 1 = ignore capture strobes
//   blank_i         : 1 = all anodes off
//   seg_o           : cathodes, active-low, [0]=CA .. [6]=CG
//   dp_o            : decimal point, active-low (upper-page marker on digit 0)
//   an_o            : anodes, active-low, [0] = rightmost digit
//   captured_o      : sticky, set by the first accepted capture
//   capture_count_o : number of accepted captures, wraps 255 -> 0
module seg7_result_display #(
    parameter int CLOCK_FREQ   = 100_000_000,
    parameter int DIGIT_HZ     = 1000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [31:0] value_i,
    input  logic               value_valid_i,
    input  logic               page_sel_i,
    input  logic               freeze_i,
    input  logic               blank_i,
    output logic        [6:0]  seg_o,
    output logic               dp_o,
    output logic        [3:0]  an_o,
    output logic               captured_o,
    output logic        [7:0]  capture_count_o
);

    localparam int DIV = CLOCK_FREQ / DIGIT_HZ;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_TERM = PW'(DIV - 1);
    localparam logic [PW-1:0] BLANK_END  = PW'(BLANK_CYCLES);

    // Standard hex font, active-low, bit order {CG,CF,CE,CD,CC,CB,CA}.
    function automatic logic [6:0] hex_font(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    logic signed [31:0] cap_q, cap_d;
    logic               captured_q, captured_d;
    logic        [7:0]  count_q, count_d;
    logic     [PW-1:0]  presc_q, presc_d;
    logic        [1:0]  idx_q, idx_d;
    logic        [6:0]  seg_q, seg_d;
    logic               dp_q, dp_d;
    logic        [3:0]  an_q, an_d;

    logic               accept;
    logic               presc_term;
    logic               dark;
    logic       [15:0]  half;
    logic        [3:0]  nib;

    always_comb begin
        accept     = value_valid_i & ~freeze_i;
        presc_term = (presc_q == PRESC_TERM);

        // Capture path: last accepted strobe wins, freeze leaves everything alone.
        cap_d      = accept ? value_i : cap_q;
        captured_d = captured_q | accept;
        count_d    = accept ? count_q + 8'd1 : count_q;

        // Prescaler and digit index; the index steps on the terminal count.
        presc_d    = presc_term ? '0 : presc_q + PW'(1);
        idx_d      = presc_term ? idx_q + 2'd1 : idx_q;

        // Outputs are built from the pre-edge state, so a capture or index
        // change that lands at edge N appears on the pins at edge N+1.
        half       = page_sel_i ? cap_q[31:16] : cap_q[15:0];
        nib        = half[{idx_q, 2'b00} +: 4];
        seg_d      = hex_font(nib);
        dp_d       = ~(page_sel_i & (idx_q == 2'd0));

        // Anti-ghosting blank at dwell start, user blank, and nothing shown
        // until a first result exists.
        dark       = (presc_q < BLANK_END) | blank_i | ~captured_q;
        an_d       = dark ? 4'b1111 : ~(4'b0001 << idx_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q      <= '0;
            captured_q <= 1'b0;
            count_q    <= 8'd0;
            presc_q    <= '0;
            idx_q      <= 2'd0;
            seg_q      <= 7'b1111111;
            dp_q       <= 1'b1;
            an_q       <= 4'b1111;
        end else begin
            cap_q      <= cap_d;
            captured_q <= captured_d;
            count_q    <= count_d;
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
        end
    end

    assign seg_o           = seg_q;
    assign dp_o            = dp_q;
    assign an_o            = an_q;
    assign captured_o      = captured_q;
    assign capture_count_o = count_q;

endmodule

// File: tb/tb_seg7_result_display.sv
// Self-checking bench for seg7_result_display with DIV=10, BLANK_CYCLES=2.
module tb_seg7_result_display;

    localparam int CF    = 1000;
    localparam int DHZ   = 100;
    localparam int BLANK = 2;
    localparam int DIV   = CF / DHZ;

    logic        clk;
    logic        rst_n;
    logic [31:0] value;
    logic        valid;
    logic        page;
    logic        freeze;
    logic        blank;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        captured;
    logic [7:0]  count;

    int n_chk  = 0;
    int n_pass = 0;

    seg7_result_display #(
        .CLOCK_FREQ  (CF),
        .DIGIT_HZ    (DHZ),
        .BLANK_CYCLES(BLANK)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .value_i        (value),
        .value_valid_i  (valid),
        .page_sel_i     (page),
        .freeze_i       (freeze),
        .blank_i        (blank),
        .seg_o          (seg),
        .dp_o           (dp),
        .an_o           (an),
        .captured_o     (captured),
        .capture_count_o(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h required %h", tag, obs, exp);
    endtask

    // ---------------- reference model ----------------
    // Display state as a function of elapsed cycles since reset release:
    // dwell phase = t mod DIV, digit = (t div DIV) mod 4.
    logic [6:0] FONT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int          m_t;
    logic [31:0] m_cap;
    logic        m_captured;
    logic [7:0]  m_count;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp;

    function automatic logic [3:0] exp_an(input int t, input logic cap, input logic blk);
        int ph;
        int idx;
        logic [3:0] oh;
        ph  = t % DIV;
        idx = (t / DIV) % 4;
        oh  = 4'b0001 << idx;
        if (ph < BLANK || blk || !cap) return 4'hF;
        return ~oh;
    endfunction

    function automatic logic [6:0] exp_seg(input int t, input logic [31:0] v, input logic pg);
        int idx;
        int base;
        logic [3:0] nib;
        idx  = (t / DIV) % 4;
        base = (pg ? 16 : 0) + 4 * idx;
        nib  = 4'((v >> base) & 32'hF);
        return FONT[nib];
    endfunction

    function automatic logic exp_dp(input int t, input logic pg);
        return !(pg && ((t / DIV) % 4 == 0));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_t        <= 0;
            m_cap      <= '0;
            m_captured <= 1'b0;
            m_count    <= 8'd0;
            e_an       <= 4'hF;
            e_seg      <= 7'h7F;
            e_dp       <= 1'b1;
        end else begin
            e_an  <= exp_an(m_t, m_captured, blank);
            e_seg <= exp_seg(m_t, m_cap, page);
            e_dp  <= exp_dp(m_t, page);
            if (valid && !freeze) begin
                m_cap      <= value;
                m_captured <= 1'b1;
                m_count    <= m_count + 8'd1;
            end
            m_t <= m_t + 1;
        end
    end

    // Continuous comparison against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("an", {28'd0, an}, {28'd0, e_an});
            chk("captured", {31'd0, captured}, {31'd0, m_captured});
            chk("count", {24'd0, count}, {24'd0, m_count});
            if (e_an != 4'hF) begin
                chk("seg", {25'd0, seg}, {25'd0, e_seg});
                chk("dp", {31'd0, dp}, {31'd0, e_dp});
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic strobe(input logic [31:0] v);
        value = v;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
    endtask

    // Observe one full frame and collect what each lit digit showed.
    task automatic run_frame(output logic [6:0] s0, output logic [6:0] s1,
                             output logic [6:0] s2, output logic [6:0] s3,
                             output int lit, output int dp0_low,
                             output int dpx_low, output int bad);
        s0 = 7'h7F; s1 = 7'h7F; s2 = 7'h7F; s3 = 7'h7F;
        lit = 0; dp0_low = 0; dpx_low = 0; bad = 0;
        for (int i = 0; i < 4 * DIV; i++) begin
            @(negedge clk);
            if (an != 4'hF) begin
                lit++;
                case (an)
                    4'b1110: begin s0 = seg; if (!dp) dp0_low++; end
                    4'b1101: begin s1 = seg; if (!dp) dpx_low++; end
                    4'b1011: begin s2 = seg; if (!dp) dpx_low++; end
                    4'b0111: begin s3 = seg; if (!dp) dpx_low++; end
                    default: bad++;
                endcase
            end
        end
    endtask

    task automatic frame_expect(input string tag, input logic [6:0] x0, input logic [6:0] x1,
                                input logic [6:0] x2, input logic [6:0] x3, input int xdp0);
        logic [6:0] s0, s1, s2, s3;
        int lit, dp0_low, dpx_low, bad;
        run_frame(s0, s1, s2, s3, lit, dp0_low, dpx_low, bad);
        chk({tag, "_d0"}, {25'd0, s0}, {25'd0, x0});
        chk({tag, "_d1"}, {25'd0, s1}, {25'd0, x1});
        chk({tag, "_d2"}, {25'd0, s2}, {25'd0, x2});
        chk({tag, "_d3"}, {25'd0, s3}, {25'd0, x3});
        chk({tag, "_lit"}, lit, 32);
        chk({tag, "_badan"}, bad, 0);
        chk({tag, "_dp0"}, dp0_low, xdp0);
        chk({tag, "_dpx"}, dpx_low, 0);
    endtask

    initial begin
        int waited;
        logic [3:0] first_lit;
        rst_n = 1'b0; value = '0; valid = 1'b0; page = 1'b0; freeze = 1'b0; blank = 1'b0;

        // Reset and pre-capture
        repeat (3) @(negedge clk);
        chk("rst_an", {28'd0, an}, 32'hF);
        chk("rst_seg", {25'd0, seg}, 32'h7F);
        chk("rst_dp", {31'd0, dp}, 32'h1);
        chk("rst_cnt", {24'd0, count}, 32'h0);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        chk("pre_an", {28'd0, an}, 32'hF);
        chk("pre_captured", {31'd0, captured}, 32'h0);
        chk("pre_cnt", {24'd0, count}, 32'h0);

        // Lower page: 0, F, b, A
        strobe(32'h1234_ABF0);
        @(negedge clk);
        frame_expect("lo", 7'h40, 7'h0E, 7'h03, 7'h08, 0);

        // Upper page: 4, 3, 2, 1 with dp on digit 0
        page = 1'b1;
        repeat (2) @(negedge clk);
        frame_expect("hi", 7'h19, 7'h30, 7'h24, 7'h79, 8);

        // Freeze ignores the strobe
        freeze = 1'b1;
        strobe(32'hFFFF_FFFF);
        freeze = 1'b0;
        @(negedge clk);
        chk("frz_cnt", {24'd0, count}, 32'd1);
        frame_expect("frz", 7'h19, 7'h30, 7'h24, 7'h79, 8);
        strobe(32'h8888_8888);
        @(negedge clk);
        chk("eight_cnt", {24'd0, count}, 32'd2);
        frame_expect("eight", 7'h00, 7'h00, 7'h00, 7'h00, 8);

        // Blank takes effect one cycle later, on a cycle that would be lit
        waited = 0;
        while ((m_t % DIV) != 5 && waited < 100) begin @(negedge clk); waited++; end
        chk("blank_wait", {31'd0, waited >= 100}, 32'd0);
        blank = 1'b1;
        @(negedge clk);
        chk("blank_an", {28'd0, an}, 32'hF);
        blank = 1'b0;
        @(negedge clk);
        chk("unblank_lit", {31'd0, an == 4'hF}, 32'd0);

        // 256 back-to-back accepted strobes wrap the counter to its start
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            value = $urandom;
            valid = 1'b1;
        end
        @(negedge clk);
        valid = 1'b0;
        @(negedge clk);
        chk("wrap_cnt", {24'd0, count}, 32'd2);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            value = $urandom;
            valid = ($urandom_range(3) == 0);
            if ($urandom_range(7) == 0)  freeze = ~freeze;
            if ($urandom_range(15) == 0) page = ~page;
            if ($urandom_range(31) == 0) blank = ~blank;
        end
        @(negedge clk);
        valid = 1'b0; freeze = 1'b0; blank = 1'b0; page = 1'b0;
        strobe(32'hCAFE_0123);

        // Mid-scan reset on dwell cycle 5 of digit 2
        waited = 0;
        while (!((m_t % DIV) == 5 && ((m_t / DIV) % 4) == 2) && waited < 200) begin
            @(negedge clk); waited++;
        end
        chk("mid_wait", {31'd0, waited >= 200}, 32'd0);
        chk("mid_pre_an", {28'd0, an}, 32'hB);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_an", {28'd0, an}, 32'hF);
        chk("mid_seg", {25'd0, seg}, 32'h7F);
        chk("mid_dp", {31'd0, dp}, 32'h1);
        chk("mid_captured", {31'd0, captured}, 32'h0);
        chk("mid_cnt", {24'd0, count}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4 * DIV) @(negedge clk);
        chk("post_an", {28'd0, an}, 32'hF);
        chk("post_captured", {31'd0, captured}, 32'h0);
        strobe(32'h0000_0005);
        waited = 0;
        while (an == 4'hF && waited < 100) begin @(negedge clk); waited++; end
        first_lit = an;
        chk("post_first_digit", {28'd0, first_lit}, 32'hE);
        chk("post_first_seg", {25'd0, seg}, 32'h12);
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/seg7_result_display.md
# seg7_result_display

Basys3 seven-segment result display, downstream of the TPU wrapper. Consumes the MLP accumulator result (`mlp_acc0_dbg`) and its valid strobe (`mlp_acc_valid_dbg`) and captures the value on each valid strobe. Shows the captured value as four hex digits on the multiplexed common-anode display, one 16-bit page at a time. Page select, freeze and blank come from the synchronized switch bank.

## Interface
- `CLOCK_FREQ`, default 100_000_000: clock frequency in Hz.
- `DIGIT_HZ`, default 1000: digit-advance rate. DIV = CLOCK_FREQ/DIGIT_HZ cycles per digit dwell. DIV ≥ 4 required.
- `BLANK_CYCLES`, default 16: anode-off cycles at the start of each dwell (anti-ghosting). 0 ≤ BLANK_CYCLES < DIV.
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `value_i`, in, 32: accumulator value, signed, shown as raw hex.
- `value_valid_i`, in, 1: single-cycle capture strobe.
- `page_sel_i`, in, 1: 0 shows bits [15:0]; 1 shows bits [31:16].
- `freeze_i`, in, 1: 1 ignores capture strobes.
- `blank_i`, in, 1: 1 turns all anodes off.
- `seg_o`, out, 7: cathodes, active-low. [0]=CA … [6]=CG.
- `dp_o`, out, 1: decimal point, active-low.
- `an_o`, out, 4: anodes, active-low. [0] = rightmost digit.
- `captured_o`, out, 1: sticky. 1 once any value has been captured.
- `capture_count_o`, out, 8: number of accepted captures, wraps 255→0.

All inputs are synchronous to `clk`; the upstream switch synchronizers provide this.

## Operation
- **Capture register (32 bits):**
  - Loads `value_i` on a cycle with `value_valid_i`=1 and `freeze_i`=0.
  - An accepted capture sets `captured_o` and increments `capture_count_o`.
  - When `freeze_i`=1 the strobe is ignored and no flag or count changes.
  - Back-to-back strobes are each accepted; the last one wins.
- **Prescaler:**
  - Counts 0..DIV-1 and wraps.
  - On the terminal count, digit index (2 bits) advances 0→1→2→3→0.
- **Digit nibble:** digit k shows nibble k of the selected half (captured[4k+3:4k] or captured[16+4k+3:16+4k]).
- **Hex font, standard.** Lowercase b and d. Values for seg_o[6:0]:
  - 0=1000000
  - 1=1111001
  - 8=0000000
  - A=0001000
  - b=0000011
  - F=0001110
- **Decimal point:** dp_o=0 only on digit 0 while `page_sel_i`=1 (upper-page marker). Otherwise dp_o=1.
- **Anode drive:**
  - an_o = one-hot-low of the digit index.
  - an_o forces to 1111 while prescaler < BLANK_CYCLES.
  - an_o forces to 1111 while `blank_i`=1.
  - an_o forces to 1111 while `captured_o`=0 (nothing shown before first result).
- **Registered outputs:** seg_o, dp_o and an_o are registered from the current index, prescaler, capture register and control inputs.
- **Reset, asserted at any time, takes effect immediately:**
  - an_o=1111, seg_o=1111111, dp_o=1.
  - captured_o=0, capture_count_o=0.
  - Capture register 0, prescaler 0, index 0.
- **Release from reset:** scanning restarts at digit 0, prescaler 0.

## Timing
- **Capture:** strobe sampled at edge N, register updated at edge N. It becomes visible in seg_o at edge N+1 if its digit is currently scanned, otherwise at that digit's next dwell. captured_o and capture_count_o update at edge N.
- **Dwell:** exactly DIV cycles per digit; frame = 4·DIV cycles.
  - Anodes are lit for DIV−BLANK_CYCLES cycles per dwell.
  - Defaults: 100 000 cycles per dwell, 4 ms frame.
- **Control latency:** a change on page_sel_i, blank_i or freeze_i is reflected on the outputs one cycle later.
- **Simultaneous events:**
  - Strobe together with freeze_i=1: ignored.
  - Strobe on the prescaler terminal cycle: the new value and the new index both apply at the next output update.
  - Count wrap 255→0 with no side effects.

## Test plan
Parameters for all scenarios: CLOCK_FREQ=1000, DIGIT_HZ=100 (DIV=10), BLANK_CYCLES=2.
- **Reset and pre-capture:** hold rst_n=0, then release and run 100 cycles with no strobe.
  - During reset: an_o=1111, seg_o=1111111, dp_o=1.
  - After release: an_o stays 1111, captured_o=0, count=0.
- **Lower-page scan:** strobe value_i=32'h1234_ABF0, page_sel_i=0.
  - an_o cycles 1110→1101→1011→0111, 8 lit cycles per 10, 2 blank cycles between digits.
  - seg_o shows 0, F, b, A on digits 0..3.
  - dp_o stays 1.
- **Upper page:** same value, page_sel_i=1.
  - Digits 0..3 show 4, 3, 2, 1.
  - dp_o=0 only while an_o=1110.
- **Freeze:** freeze_i=1, strobe 32'hFFFF_FFFF.
  - Display and count unchanged.
  - Release freeze and strobe 32'h8888_8888: all digits show seg_o=0000000 and count increments by 1.
- **Blank and wrap:**
  - blank_i=1: an_o=1111 one cycle later.
  - 256 accepted strobes: capture_count_o returns to its start value.
- **Mid-scan reset:** assert rst_n on dwell cycle 5 of digit 2.
  - Outputs are blanked in the same cycle, without waiting for a clock edge.
  - After release, digit 0 is scanned first and stays dark until a new capture.
